// File: rtl/parity_pkg.sv
// Shared types for the parity arbiter: FSM states, grant encoding, default widths.
package parity_pkg;

    localparam int DW_DEFAULT  = 4;
    localparam int ECW_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef enum logic {
        GNT_GEN = 1'b0,
        GNT_CHK = 1'b1
    } grant_t;

endpackage

// File: rtl/parity_arbiter_if.sv
// Request/response handshake bundle between the nibble producers/consumers and the arbiter.
interface parity_arbiter_if
    import parity_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int ECW = ECW_DEFAULT
);
    logic           genvalid;
    logic           genready;
    logic [DW-1:0]  gendata;
    logic           chkvalid;
    logic           chkready;
    logic [DW-1:0]  chkdata;
    logic           chkparity;
    logic           genresvalid;
    logic           genresready;
    logic           genparity;
    logic           chkresvalid;
    logic           chkresready;
    logic           chkerr;
    logic [ECW-1:0] errcount;
    logic           clrerr;

    modport master (
        output genvalid, gendata, chkvalid, chkdata, chkparity,
               genresready, chkresready, clrerr,
        input  genready, chkready, genresvalid, genparity,
               chkresvalid, chkerr, errcount
    );

    modport slave (
        input  genvalid, gendata, chkvalid, chkdata, chkparity,
               genresready, chkresready, clrerr,
        output genready, chkready, genresvalid, genparity,
               chkresvalid, chkerr, errcount
    );

endinterface

// File: rtl/parity_engine.sv
// Combinational odd-parity engine: generates a parity bit (mode 0) or flags an error (mode 1).
module parity_engine
    import parity_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          mode,
    input  logic [DW-1:0] datain,
    input  logic          paritybit,
    output logic          result
);

    // Odd parity: a valid word plus its parity bit carries an odd number of ones.
    always_comb begin
        if (mode) begin
            result = ~^{datain, paritybit};
        end else begin
            result = ~^datain;
        end
    end

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity engine between generate and check requesters,
// with one registered result outstanding at a time and a saturating error counter.
module parity_arbiter
    import parity_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int ECW = ECW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    parity_arbiter_if.slave bus
);

    state_t         r_state;
    state_t         w_state_nxt;
    grant_t         r_lastgrant;
    grant_t         w_grant;
    logic           w_genready;
    logic           w_chkready;
    logic           w_gen_done;
    logic           w_chk_done;
    logic           w_mode;
    logic [DW-1:0]  w_datain;
    logic           w_result;
    logic           r_genresvalid;
    logic           r_chkresvalid;
    logic           r_genparity;
    logic           r_chkerr;
    logic [ECW-1:0] r_errcount;

    assign w_gen_done = r_genresvalid & bus.genresready;
    assign w_chk_done = r_chkresvalid & bus.chkresready;

    // On a tie the side that was not served last wins; a lone valid always wins.
    always_comb begin
        w_grant = GNT_GEN;
        if (bus.genvalid && bus.chkvalid) begin
            w_grant = (r_lastgrant == GNT_CHK) ? GNT_GEN : GNT_CHK;
        end else if (bus.chkvalid) begin
            w_grant = GNT_CHK;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_genready  = 1'b0;
        w_chkready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_genready = !rst && bus.genvalid && (w_grant == GNT_GEN);
                w_chkready = !rst && bus.chkvalid && (w_grant == GNT_CHK);
                if (w_genready || w_chkready) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_gen_done || w_chk_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastgrant <= GNT_CHK;
        end else begin
            r_state <= w_state_nxt;
            if (w_genready) begin
                r_lastgrant <= GNT_GEN;
            end else if (w_chkready) begin
                r_lastgrant <= GNT_CHK;
            end
        end
    end

    assign w_mode   = (w_grant == GNT_CHK);
    assign w_datain = w_mode ? bus.chkdata : bus.gendata;

    parity_engine #(
        .DW(DW)
    ) u_engine (
        .mode     (w_mode),
        .datain   (w_datain),
        .paritybit(bus.chkparity),
        .result   (w_result)
    );

    // Result registers clear on handshake so the idle side always reads back zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_genresvalid <= 1'b0;
            r_genparity   <= 1'b0;
            r_chkresvalid <= 1'b0;
            r_chkerr      <= 1'b0;
        end else begin
            if (w_genready) begin
                r_genresvalid <= 1'b1;
                r_genparity   <= w_result;
            end else if (w_gen_done) begin
                r_genresvalid <= 1'b0;
                r_genparity   <= 1'b0;
            end
            if (w_chkready) begin
                r_chkresvalid <= 1'b1;
                r_chkerr      <= w_result;
            end else if (w_chk_done) begin
                r_chkresvalid <= 1'b0;
                r_chkerr      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errcount <= '0;
        end else if (bus.clrerr) begin
            r_errcount <= '0;
        end else if (w_chkready && w_result && (r_errcount != {ECW{1'b1}})) begin
            r_errcount <= r_errcount + ECW'(1);
        end
    end

    assign bus.genready    = w_genready;
    assign bus.chkready    = w_chkready;
    assign bus.genresvalid = r_genresvalid;
    assign bus.genparity   = r_genparity;
    assign bus.chkresvalid = r_chkresvalid;
    assign bus.chkerr      = r_chkerr;
    assign bus.errcount    = r_errcount;

endmodule

// File: tb/tb_parity_arbiter.sv
// Self-checking bench for parity_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_parity_arbiter;
    import parity_pkg::*;

    localparam int DW  = 4;
    localparam int ECW = 2;

    typedef struct {
        logic          is_chk;
        logic [DW-1:0] data;
        logic          par;
        logic          exp;
    } vec_t;

    typedef struct {
        logic is_chk;
        logic val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   m_err;
    exp_t sb[$];
    vec_t vecs[8];

    parity_arbiter_if #(.DW(DW), .ECW(ECW)) bus ();

    parity_arbiter #(.DW(DW), .ECW(ECW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_chk, input logic val);
        exp_t e;
        e.is_chk = is_chk;
        e.val    = val;
        sb.push_back(e);
        if (is_chk && val && m_err != 3) m_err++;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 8'd1, 8'd0);
            return;
        end
        e = sb.pop_front();
        check({name, "_genresvalid"}, bus.genresvalid, !e.is_chk);
        check({name, "_chkresvalid"}, bus.chkresvalid, e.is_chk);
        check({name, "_genparity"}, bus.genparity, e.is_chk ? 1'b0 : e.val);
        check({name, "_chkerr"}, bus.chkerr, e.is_chk ? e.val : 1'b0);
        check({name, "_errcount"}, 8'(bus.errcount), 8'(m_err));
    endtask

    // Starts at a falling edge in IDLE and returns at a falling edge in IDLE.
    task automatic run_req(input string name, input logic is_chk, input logic [DW-1:0] d,
                           input logic p, input logic e);
        int n;
        n = 0;
        if (is_chk) begin
            bus.chkvalid = 1'b1; bus.chkdata = d; bus.chkparity = p;
        end else begin
            bus.genvalid = 1'b1; bus.gendata = d;
        end
        #1;
        while (!(is_chk ? bus.chkready : bus.genready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_accept_wait"}, 8'(n), 8'd0);
        if (n < 20) push_exp(is_chk, e);
        @(negedge clk);
        bus.genvalid = 1'b0;
        bus.chkvalid = 1'b0;
        #1;
        pop_check(name);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; m_err = 0;
        rst = 1'b1;
        bus.genvalid = 1'b1; bus.gendata = '0;
        bus.chkvalid = 1'b1; bus.chkdata = '0; bus.chkparity = 1'b0;
        bus.genresready = 1'b1; bus.chkresready = 1'b1; bus.clrerr = 1'b0;

        vecs[0] = '{1'b0, 4'b1010, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'b1010, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'b1010, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'b1111, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 4'b1111, 1'b1, 1'b0};

        // Reset state, with both valids high to show readys stay low.
        repeat (2) @(negedge clk);
        #1;
        check("rst_genready", bus.genready, 1'b0);
        check("rst_chkready", bus.chkready, 1'b0);
        check("rst_genresvalid", bus.genresvalid, 1'b0);
        check("rst_chkresvalid", bus.chkresvalid, 1'b0);
        check("rst_genparity", bus.genparity, 1'b0);
        check("rst_chkerr", bus.chkerr, 1'b0);
        check("rst_errcount", 8'(bus.errcount), 8'd0);

        // Contention: accepts alternate gen, chk, gen, chk on even cycles.
        @(negedge clk);
        rst = 1'b0;
        bus.gendata = 4'b1010;
        bus.chkdata = 4'b1010; bus.chkparity = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                check($sformatf("tie%0d_genready", c), bus.genready, (c % 4 == 0));
                check($sformatf("tie%0d_chkready", c), bus.chkready, (c % 4 != 0));
                push_exp((c % 4 != 0), 1'b1);
            end else begin
                check($sformatf("tie%0d_busy_ready", c), {bus.genready, bus.chkready}, 2'b00);
                pop_check($sformatf("tie%0d_resp", c));
            end
            @(negedge clk);
        end
        bus.genvalid = 1'b0;
        bus.chkvalid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].is_chk, vecs[i].data, vecs[i].par, vecs[i].exp);
        end

        // Back-pressure on the generate result.
        bus.genresready = 1'b0;
        bus.genvalid = 1'b1; bus.gendata = 4'b1010;
        #1;
        check("bp_accept", bus.genready, 1'b1);
        push_exp(1'b0, 1'b1);
        @(negedge clk);
        bus.genvalid = 1'b0;
        bus.chkvalid = 1'b1; bus.chkdata = 4'b1010; bus.chkparity = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_genresvalid", k), bus.genresvalid, 1'b1);
            check($sformatf("bp%0d_genparity", k), bus.genparity, 1'b1);
            check($sformatf("bp%0d_readys", k), {bus.genready, bus.chkready}, 2'b00);
            @(negedge clk);
        end
        bus.genresready = 1'b1;
        #1;
        pop_check("bp_gen_resp");
        @(negedge clk);
        #1;
        check("bp_resume_chkready", bus.chkready, 1'b1);
        push_exp(1'b1, 1'b0);
        @(negedge clk);
        bus.chkvalid = 1'b0;
        #1;
        pop_check("bp_chk_resp");
        @(negedge clk);

        // Saturating counter with ECW = 2.
        bus.clrerr = 1'b1;
        @(negedge clk);
        bus.clrerr = 1'b0;
        m_err = 0;
        #1;
        check("clr_errcount", 8'(bus.errcount), 8'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            run_req($sformatf("sat%0d", i), 1'b1, 4'b1010, 1'b0, 1'b1);
            check($sformatf("sat%0d_count", i), 8'(bus.errcount), (i < 3) ? 8'(i + 1) : 8'd3);
        end

        // clrerr coinciding with an error registration.
        bus.chkvalid = 1'b1; bus.chkdata = 4'b0000; bus.chkparity = 1'b0;
        bus.clrerr = 1'b1;
        #1;
        check("clrwin_chkready", bus.chkready, 1'b1);
        push_exp(1'b1, 1'b1);
        m_err = 0;
        @(negedge clk);
        bus.clrerr = 1'b0;
        bus.chkvalid = 1'b0;
        #1;
        pop_check("clrwin_resp");
        check("clrwin_count", 8'(bus.errcount), 8'd0);
        @(negedge clk);

        // Reset mid-operation with a result outstanding and a nonzero count.
        run_req("pre_rst", 1'b1, 4'b0110, 1'b0, 1'b1);
        bus.genresready = 1'b0;
        bus.genvalid = 1'b1; bus.gendata = 4'b1010;
        #1;
        push_exp(1'b0, 1'b1);
        @(negedge clk);
        bus.genvalid = 1'b0;
        #1;
        check("mid_rst_pre_valid", bus.genresvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_genresvalid", bus.genresvalid, 1'b0);
        check("mid_rst_genparity", bus.genparity, 1'b0);
        check("mid_rst_chkresvalid", bus.chkresvalid, 1'b0);
        check("mid_rst_errcount", 8'(bus.errcount), 8'd0);
        sb.delete();
        m_err = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.genresready = 1'b1;
        bus.genvalid = 1'b1; bus.gendata = 4'b0000;
        bus.chkvalid = 1'b1; bus.chkdata = 4'b0000; bus.chkparity = 1'b0;
        #1;
        check("post_rst_tie_gen", bus.genready, 1'b1);
        check("post_rst_tie_chk", bus.chkready, 1'b0);
        push_exp(1'b0, 1'b1);
        @(negedge clk);
        bus.genvalid = 1'b0;
        bus.chkvalid = 1'b0;
        #1;
        pop_check("post_rst_resp");
        @(negedge clk);

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
